// File: rtl/decode_queue_if.sv
// Handshake bundle between the fetch side, the decode queue and the execute stage.
// The master modport is the environment (upstream producer plus downstream consumer).
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_opcode;
    logic [2:0]      out_func3;
    logic            out_func7;
    logic            out_func7_mul;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_rs1_en;
    logic            out_rs2_en;
    logic            out_rd_we;
    logic            out_illegal;
    logic [CW-1:0]   out_count;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_func7_mul,
               out_rs1, out_rs2, out_rd, out_imm, out_pc, out_rs1_en, out_rs2_en,
               out_rd_we, out_illegal, out_count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_func7, out_func7_mul,
               out_rs1, out_rs2, out_rd, out_imm, out_pc, out_rs1_en, out_rs2_en,
               out_rd_we, out_illegal, out_count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32IM decode stage: instructions are decoded on acceptance and held in a
// DEPTH-entry FIFO of decoded bundles; the head bundle drives the execute side.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_MISC   = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [4:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic            func7_mul;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    bundle_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [31:0]     w_inst;
    logic [4:0]      w_opc;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic            w_legal;
    logic            w_rs1_en;
    logic            w_rs2_en;
    logic            w_rd_we;
    bundle_t         w_dec;
    bundle_t         w_head;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;

    assign w_inst = bus.in_inst;
    assign w_opc  = w_inst[6:2];

    // Signed size casts sign-extend from inst[31] to whatever XLEN is.
    assign w_imm_i = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));

    always_comb begin
        w_legal  = 1'b0;
        w_imm    = '0;
        w_rs1_en = 1'b0;
        w_rs2_en = 1'b0;
        w_rd_we  = 1'b0;
        case (w_opc)
            OP_LOAD, OP_MISC, OP_IMM, OP_JALR, OP_SYSTEM: begin
                w_legal  = 1'b1;
                w_imm    = w_imm_i;
                w_rs1_en = 1'b1;
                w_rd_we  = (w_opc != OP_MISC);
            end
            OP_STORE: begin
                w_legal  = 1'b1;
                w_imm    = w_imm_s;
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
            end
            OP_BRANCH: begin
                w_legal  = 1'b1;
                w_imm    = w_imm_b;
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_legal  = 1'b1;
                w_imm    = w_imm_u;
                w_rd_we  = 1'b1;
            end
            OP_JAL: begin
                w_legal  = 1'b1;
                w_imm    = w_imm_j;
                w_rd_we  = 1'b1;
            end
            OP_OP: begin
                w_legal  = 1'b1;
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_rd_we  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (w_inst[1:0] != 2'b11) begin
            w_legal = 1'b0;
        end
    end

    // Raw fields pass through for every entry; only the derived ones are gated by legality.
    always_comb begin
        w_dec           = '0;
        w_dec.opcode    = w_opc;
        w_dec.func3     = w_inst[14:12];
        w_dec.func7     = w_inst[30];
        w_dec.func7_mul = (w_opc == OP_OP) ? w_inst[25] : 1'b0;
        w_dec.rs1       = w_inst[19:15];
        w_dec.rs2       = w_inst[24:20];
        w_dec.rd        = w_inst[11:7];
        w_dec.imm       = w_legal ? w_imm : '0;
        w_dec.pc        = bus.in_pc;
        w_dec.rs1_en    = w_legal & w_rs1_en;
        w_dec.rs2_en    = w_legal & w_rs2_en;
        w_dec.rd_we     = w_legal & w_rd_we & (w_inst[11:7] != 5'd0);
        w_dec.illegal   = ~w_legal;
    end

    assign bus.in_ready  = (r_count < CW'(DEPTH));
    assign bus.out_valid = (r_count != '0);
    assign bus.out_count = r_count;

    assign w_push = bus.in_valid & bus.in_ready & ~flush;
    assign w_pop  = bus.out_valid & bus.out_ready & ~flush;

    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.out_opcode    = w_head.opcode;
    assign bus.out_func3     = w_head.func3;
    assign bus.out_func7     = w_head.func7;
    assign bus.out_func7_mul = w_head.func7_mul;
    assign bus.out_rs1       = w_head.rs1;
    assign bus.out_rs2       = w_head.rs2;
    assign bus.out_rd        = w_head.rd;
    assign bus.out_imm       = w_head.imm;
    assign bus.out_pc        = w_head.pc;
    assign bus.out_rs1_en    = w_head.rs1_en;
    assign bus.out_rs2_en    = w_head.rs2_en;
    assign bus.out_rd_we     = w_head.rd_we;
    assign bus.out_illegal   = w_head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: expected bundles are queued when an
// instruction is offered and compared when it reaches the head of the queue.
module tb_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    logic flush;

    decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic        func7;
        logic        func7_mul;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Raw fields are plain slices of the instruction; derived ones are given explicitly.
    task automatic expect_entry(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] imm,
                                input logic f7m, input logic r1, input logic r2, input logic we,
                                input logic ill);
        exp_t e;
        e.opcode    = inst[6:2];
        e.func3     = inst[14:12];
        e.func7     = inst[30];
        e.func7_mul = f7m;
        e.rs1       = inst[19:15];
        e.rs2       = inst[24:20];
        e.rd        = inst[11:7];
        e.imm       = imm;
        e.pc        = pc;
        e.rs1_en    = r1;
        e.rs2_en    = r2;
        e.rd_we     = we;
        e.illegal   = ill;
        sb.push_back(e);
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
            return;
        end
        e = sb.pop_front();
        chk({tag, "_opcode"},    64'(bus.out_opcode),    64'(e.opcode));
        chk({tag, "_func3"},     64'(bus.out_func3),     64'(e.func3));
        chk({tag, "_func7"},     64'(bus.out_func7),     64'(e.func7));
        chk({tag, "_func7_mul"}, 64'(bus.out_func7_mul), 64'(e.func7_mul));
        chk({tag, "_rs1"},       64'(bus.out_rs1),       64'(e.rs1));
        chk({tag, "_rs2"},       64'(bus.out_rs2),       64'(e.rs2));
        chk({tag, "_rd"},        64'(bus.out_rd),        64'(e.rd));
        chk({tag, "_imm"},       64'(bus.out_imm),       64'(e.imm));
        chk({tag, "_pc"},        64'(bus.out_pc),        64'(e.pc));
        chk({tag, "_rs1_en"},    64'(bus.out_rs1_en),    64'(e.rs1_en));
        chk({tag, "_rs2_en"},    64'(bus.out_rs2_en),    64'(e.rs2_en));
        chk({tag, "_rd_we"},     64'(bus.out_rd_we),     64'(e.rd_we));
        chk({tag, "_illegal"},   64'(bus.out_illegal),   64'(e.illegal));
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("push_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pop(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1));
        check_head(tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_count",     64'(bus.out_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset with two entries queued
        push(32'hFFF30293, 32'h100);
        push(32'h022081B3, 32'h104);
        chk("pre_rst_count", 64'(bus.out_count), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid),  64'(0));
        chk("arst_in_ready",  64'(bus.in_ready),   64'(1));
        chk("arst_count",     64'(bus.out_count),  64'(0));
        chk("arst_opcode",    64'(bus.out_opcode), 64'(0));
        chk("arst_rd",        64'(bus.out_rd),     64'(0));
        chk("arst_imm",       64'(bus.out_imm),    64'(0));
        chk("arst_pc",        64'(bus.out_pc),     64'(0));
        chk("arst_rd_we",     64'(bus.out_rd_we),  64'(0));
        rst_n = 1'b1;

        // addi x5,x6,-1: visible right after the accepting edge
        expect_entry(32'hFFF30293, 32'h100, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        push(32'hFFF30293, 32'h100);
        chk("addi_latency_valid", 64'(bus.out_valid), 64'(1));
        chk("addi_latency_count", 64'(bus.out_count), 64'(1));
        pop("addi");

        // beq x1,x2,-4 and mul x3,x1,x2
        expect_entry(32'hFE208EE3, 32'h108, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(32'hFE208EE3, 32'h108);
        expect_entry(32'h022081B3, 32'h10C, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h022081B3, 32'h10C);
        pop("beq");
        pop("mul");

        // Backpressure: addi x1,x0,1 / lui x2,0x12345 fill; sw x2,8(x1) waits upstream
        expect_entry(32'h00100093, 32'h200, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        push(32'h00100093, 32'h200);
        expect_entry(32'h12345137, 32'h204, 32'h12345000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'h12345137, 32'h204);
        chk("bp_full_in_ready", 64'(bus.in_ready),  64'(0));
        chk("bp_full_count",    64'(bus.out_count), 64'(2));
        expect_entry(32'h0020A423, 32'h208, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0020A423;
        bus.in_pc    = 32'h208;
        repeat (2) @(negedge clk);
        chk("bp_held_in_ready", 64'(bus.in_ready),  64'(0));
        chk("bp_held_count",    64'(bus.out_count), 64'(2));
        check_head("bp_a");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_pop_in_ready", 64'(bus.in_ready),  64'(1));
        chk("bp_after_pop_count",    64'(bus.out_count), 64'(1));
        @(negedge clk);
        check_head("bp_b");
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_pushpop_count", 64'(bus.out_count), 64'(1));
        pop("bp_c");
        chk("bp_drained_count", 64'(bus.out_count), 64'(0));

        // Illegal encodings, then addi x0,x0,0 and jal x1,16
        expect_entry(32'h00000000, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(32'h00000000, 32'h300);
        expect_entry(32'h0000007F, 32'h304, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(32'h0000007F, 32'h304);
        pop("ill_zero");
        pop("ill_7f");
        expect_entry(32'h00000013, 32'h308, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h00000013, 32'h308);
        expect_entry(32'h010000EF, 32'h30C, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'h010000EF, 32'h30C);
        pop("nop");
        pop("jal");

        // Flush while full, with a same-cycle push and pop offered
        push(32'h00100093, 32'h400);
        push(32'h00200113, 32'h404);
        chk("fl_pre_count", 64'(bus.out_count), 64'(2));
        @(negedge clk);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00500293;
        bus.in_pc     = 32'h408;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'(0));
        chk("fl_count",     64'(bus.out_count), 64'(0));
        chk("fl_in_ready",  64'(bus.in_ready),  64'(1));
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("fl_stays_empty", 64'(bus.out_valid), 64'(0));
        end

        // Pop on an empty queue is ignored
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("empty_pop_count", 64'(bus.out_count), 64'(0));

        // Post-flush entry is the only thing seen (auipc x7,0x1)
        expect_entry(32'h00001397, 32'h500, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'h00001397, 32'h500);
        pop("post_flush");
        chk("final_count", 64'(bus.out_count), 64'(0));
        chk("sb_drained",  64'(sb.size()),     64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, flow-controlled RV32IM decode stage that generalises the combinational field decoder.
- Accepts raw instructions with their PC over a valid/ready handshake and decodes each one at acceptance.
- Stores up to DEPTH decoded bundles in a FIFO and presents the head bundle to the execute stage over a second valid/ready handshake.
- Adds immediate generation, register-use enables, illegal-instruction flagging and pipeline flush.

Parameters:
- XLEN, 32, immediate/PC width (>=32); immediates sign-extend to XLEN.
- DEPTH, 2, number of decoded-bundle FIFO entries (>=1; need not be a power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all queued entries and any same-cycle input.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  queue can accept; registered, equals (count < DEPTH).
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  downstream consumes head.
- out_opcode  out  5  inst[6:2].
- out_func3  out  3  inst[14:12].
- out_func7  out  1  inst[30].
- out_func7_mul  out  1  inst[25] when opcode=OP, else 0.
- out_rs1  out  5  inst[19:15].
- out_rs2  out  5  inst[24:20].
- out_rd  out  5  inst[11:7].
- out_imm  out  XLEN  decoded immediate.
- out_pc  out  XLEN  PC of head entry.
- out_rs1_en  out  1  rs1 is read.
- out_rs2_en  out  1  rs2 is read.
- out_rd_we  out  1  rd is written.
- out_illegal  out  1  unsupported or malformed encoding.
- out_count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst_n=0): count=0, read/write pointers=0, all storage=0; out_valid=0, in_ready=1, all out_* fields=0.
- Push when in_valid&in_ready&!flush: decode in_inst combinationally and write the bundle at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop when out_valid&out_ready&!flush: rd_ptr advances and wraps the same way.
- Latency: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N when the queue was empty; there is no same-cycle bypass.
- Push and pop in the same cycle: count unchanged. A pop when empty is ignored. A push when full cannot occur, because in_ready=0.
- in_ready depends only on registered count; there is no combinational path from out_ready.
- Flush: at the next edge count=0 and pointers=0. A same-cycle push is dropped and a same-cycle pop is not counted. Storage is not cleared.
- out_* fields come from the head entry and are checked only while out_valid=1.
- Legal opcodes (inst[1:0] must be 2'b11), by inst[6:2]:
  - LOAD 00000, MISC-MEM 00011, OP-IMM 00100, JALR 11001, SYSTEM 11100: I-immediate.
  - STORE 01000: S-immediate.
  - BRANCH 11000: B-immediate.
  - LUI 01101, AUIPC 00101: U-immediate.
  - JAL 11011: J-immediate.
  - OP 01100: R-type, immediate 0.
- Immediate formats, all sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Register-use enables:
  - rs1_en = 1 except for LUI, AUIPC, JAL.
  - rs2_en = 1 only for STORE, OP, BRANCH.
  - rd_we = 1 except for STORE, BRANCH, MISC-MEM, and forced 0 when rd=0.
- Illegal: set when inst[1:0]!=2'b11 or the opcode is not listed. An illegal entry forces imm=0, rs1_en=rs2_en=rd_we=0 and is still queued in order.
- Raw field outputs (opcode, func3, func7, rs1, rs2, rd) pass through unchanged for every entry, legal or illegal.

Test Plan:
1. Reset mid-stream: DEPTH=2, push two entries, pulse rst_n low asynchronously between edges -> immediately out_valid=0, in_ready=1, out_count=0, all out_* fields 0.
2. Push addi x5,x6,-1 (0xFFF30293, pc 0x100) into an empty queue -> one cycle later out_valid=1, opcode=00100, rd=5, rs1=6, imm=0xFFFFFFFF, rs1_en=1, rs2_en=0, rd_we=1, illegal=0, pc=0x100.
3. Push beq x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, rs1_en=1, rs2_en=1, rd_we=0. Push mul x3,x1,x2 (0x022081B3) -> func7_mul=1, rd_we=1, imm=0.
4. Backpressure, DEPTH=2, out_ready=0: push A, B, then offer C -> in_ready=0 after B with C held upstream. Raise out_ready -> A, B, C emerge in order and in_ready returns to 1 after the first pop.
5. Illegal encodings: push 0x00000000 and 0x0000007F -> both out_illegal=1, rd_we=0, imm=0, both dequeued in order. Push addi x0,x0,0 (0x00000013) -> legal with rd_we=0.
6. Flush with count=2 while in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_count=0, and the flushed-cycle input never appears at the output.
